// File: rtl/pass_scheduler_pkg.sv
// Shared definitions for the multi-pass Smith-Waterman scheduler: array geometry
// defaults and the scheduler state encoding.
package pass_scheduler_pkg;

    localparam int PE_NUM_DEF  = 64;
    localparam int LEN_W_DEF   = 12;
    localparam int MAX_LAT_DEF = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_S = 2'd1,
        STREAM = 2'd2,
        RESULT = 2'd3
    } state_t;

endpackage

// File: rtl/pass_scheduler_if.sv
// Start/result handshake plus the memory, PE-array and max-tree control bundle
// driven by the pass scheduler (master) and observed by its environment (slave).
interface pass_scheduler_if #(
    parameter int PE_NUM = pass_scheduler_pkg::PE_NUM_DEF,
    parameter int LEN_W  = pass_scheduler_pkg::LEN_W_DEF
);
    localparam int IDX_W = $clog2(PE_NUM);

    logic              i_start;
    logic [LEN_W-1:0]  i_s_len;
    logic [LEN_W-1:0]  i_t_len;
    logic              i_stall;

    logic              o_busy;
    logic              o_done;
    logic              o_max_init;
    logic              o_s_load;
    logic [IDX_W-1:0]  o_s_idx;
    logic [LEN_W-1:0]  o_s_addr;
    logic [PE_NUM-1:0] o_pe_mask;
    logic              o_newline;
    logic              o_t_push;
    logic [LEN_W-1:0]  o_t_addr;
    logic              o_t_src;
    logic              o_cap_en;
    logic [LEN_W-1:0]  o_cap_addr;
    logic              o_lock;
    logic [LEN_W-1:0]  o_pass;

    modport master (
        input  i_start, i_s_len, i_t_len, i_stall,
        output o_busy, o_done, o_max_init, o_s_load, o_s_idx, o_s_addr, o_pe_mask,
               o_newline, o_t_push, o_t_addr, o_t_src, o_cap_en, o_cap_addr,
               o_lock, o_pass
    );

    modport slave (
        output i_start, i_s_len, i_t_len, i_stall,
        input  o_busy, o_done, o_max_init, o_s_load, o_s_idx, o_s_addr, o_pe_mask,
               o_newline, o_t_push, o_t_addr, o_t_src, o_cap_en, o_cap_addr,
               o_lock, o_pass
    );

endinterface

// File: rtl/pass_scheduler.sv
// Splits the query into PE_NUM-wide passes, loads each segment into the PEs and
// streams the database through the array, recirculating last-PE outputs between passes.
module pass_scheduler
    import pass_scheduler_pkg::*;
#(
    parameter int PE_NUM  = PE_NUM_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int MAX_LAT = MAX_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    pass_scheduler_if.master bus
);
    localparam int IDX_W = $clog2(PE_NUM);
    localparam int NA_W  = IDX_W + 1;
    localparam int LAT_W = $clog2(MAX_LAT + 2);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  s_len_q, s_len_d, t_len_q, t_len_d;
    logic [LEN_W-1:0]  pass_q, pass_d, adv_q, adv_d;
    logic [IDX_W-1:0]  ld_idx_q, ld_idx_d;
    logic [LAT_W-1:0]  lat_q, lat_d;

    logic              busy_q, busy_d, done_q, done_d, max_init_q, max_init_d;
    logic              s_load_q, s_load_d, newline_q, newline_d;
    logic              t_push_q, t_push_d, t_src_q, t_src_d, cap_en_q, cap_en_d;
    logic [IDX_W-1:0]  s_idx_q, s_idx_d;
    logic [LEN_W-1:0]  s_addr_q, s_addr_d, t_addr_q, t_addr_d;
    logic [LEN_W-1:0]  cap_addr_q, cap_addr_d, opass_q, opass_d;
    logic [PE_NUM-1:0] pe_mask_q, pe_mask_d;

    logic [LEN_W:0]    n_pass;
    logic              is_last;
    logic [NA_W-1:0]   n_act;
    logic [LEN_W-1:0]  n_act_l;
    logic [PE_NUM-1:0] mask_w;
    logic              adv_last;

    // Pass geometry: only the final pass can be partial, and its width is S_len mod PE_NUM.
    always_comb begin
        n_pass  = ({1'b0, s_len_q} + (LEN_W+1)'(PE_NUM - 1)) >> IDX_W;
        is_last = ({1'b0, pass_q} == n_pass - (LEN_W+1)'(1));
        if (is_last && (s_len_q[IDX_W-1:0] != '0)) n_act = {1'b0, s_len_q[IDX_W-1:0]};
        else                                        n_act = NA_W'(PE_NUM);
        n_act_l  = LEN_W'(n_act);
        mask_w   = ~({PE_NUM{1'b1}} << n_act);
        adv_last = (adv_q == t_len_q + n_act_l - LEN_W'(1));
    end

    always_comb begin
        state_d    = state_q;
        s_len_d    = s_len_q;
        t_len_d    = t_len_q;
        pass_d     = pass_q;
        adv_d      = adv_q;
        ld_idx_d   = ld_idx_q;
        lat_d      = lat_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        max_init_d = 1'b0;
        s_load_d   = 1'b0;
        s_idx_d    = s_idx_q;
        s_addr_d   = s_addr_q;
        pe_mask_d  = '0;
        newline_d  = 1'b0;
        t_push_d   = 1'b0;
        t_addr_d   = t_addr_q;
        t_src_d    = t_src_q;
        cap_en_d   = 1'b0;
        cap_addr_d = cap_addr_q;
        opass_d    = pass_q;

        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    s_len_d    = bus.i_s_len;
                    t_len_d    = bus.i_t_len;
                    busy_d     = 1'b1;
                    max_init_d = 1'b1;
                    pass_d     = '0;
                    ld_idx_d   = '0;
                    lat_d      = '0;
                    state_d    = ((bus.i_s_len == '0) || (bus.i_t_len == '0)) ? RESULT : LOAD_S;
                end
            end
            LOAD_S: begin
                s_load_d  = 1'b1;
                s_idx_d   = ld_idx_q;
                s_addr_d  = (pass_q << IDX_W) | LEN_W'(ld_idx_q);
                pe_mask_d = mask_w;
                if (NA_W'(ld_idx_q) == n_act - NA_W'(1)) begin
                    ld_idx_d = '0;
                    adv_d    = '0;
                    state_d  = STREAM;
                end else begin
                    ld_idx_d = ld_idx_q + IDX_W'(1);
                end
            end
            STREAM: begin
                pe_mask_d = mask_w;
                // A stalled cycle emits nothing and leaves adv where it is.
                if (!bus.i_stall) begin
                    newline_d  = (adv_q == '0);
                    t_push_d   = (adv_q < t_len_q);
                    t_addr_d   = adv_q;
                    t_src_d    = (pass_q != '0);
                    cap_en_d   = (adv_q >= n_act_l) && !is_last;
                    cap_addr_d = adv_q - n_act_l;
                    if (adv_last) begin
                        adv_d = '0;
                        if (is_last) begin
                            lat_d   = '0;
                            state_d = RESULT;
                        end else begin
                            pass_d  = pass_q + LEN_W'(1);
                            state_d = LOAD_S;
                        end
                    end else begin
                        adv_d = adv_q + LEN_W'(1);
                    end
                end
            end
            RESULT: begin
                if (lat_q == LAT_W'(MAX_LAT)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = '0;
                    state_d = IDLE;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            s_len_q    <= '0;
            t_len_q    <= '0;
            pass_q     <= '0;
            adv_q      <= '0;
            ld_idx_q   <= '0;
            lat_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            max_init_q <= 1'b0;
            s_load_q   <= 1'b0;
            s_idx_q    <= '0;
            s_addr_q   <= '0;
            pe_mask_q  <= '0;
            newline_q  <= 1'b0;
            t_push_q   <= 1'b0;
            t_addr_q   <= '0;
            t_src_q    <= 1'b0;
            cap_en_q   <= 1'b0;
            cap_addr_q <= '0;
            opass_q    <= '0;
        end else begin
            state_q    <= state_d;
            s_len_q    <= s_len_d;
            t_len_q    <= t_len_d;
            pass_q     <= pass_d;
            adv_q      <= adv_d;
            ld_idx_q   <= ld_idx_d;
            lat_q      <= lat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            max_init_q <= max_init_d;
            s_load_q   <= s_load_d;
            s_idx_q    <= s_idx_d;
            s_addr_q   <= s_addr_d;
            pe_mask_q  <= pe_mask_d;
            newline_q  <= newline_d;
            t_push_q   <= t_push_d;
            t_addr_q   <= t_addr_d;
            t_src_q    <= t_src_d;
            cap_en_q   <= cap_en_d;
            cap_addr_q <= cap_addr_d;
            opass_q    <= opass_d;
        end
    end

    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;
    assign bus.o_max_init = max_init_q;
    assign bus.o_s_load   = s_load_q;
    assign bus.o_s_idx    = s_idx_q;
    assign bus.o_s_addr   = s_addr_q;
    assign bus.o_pe_mask  = pe_mask_q;
    assign bus.o_newline  = newline_q;
    assign bus.o_t_push   = t_push_q;
    assign bus.o_t_addr   = t_addr_q;
    assign bus.o_t_src    = t_src_q;
    assign bus.o_cap_en   = cap_en_q;
    assign bus.o_cap_addr = cap_addr_q;
    assign bus.o_pass     = opass_q;
    // The array must freeze in the very cycle the stall is raised.
    assign bus.o_lock     = bus.i_stall & (state_q == STREAM);

endmodule

// File: tb/tb_pass_scheduler.sv
// Bench for pass_scheduler: a job-level reference model expands each start into an
// ordered list of load/advance/wait actions and predicts every output cycle by cycle.
module tb_pass_scheduler;
    localparam int PE_NUM  = 4;
    localparam int LEN_W   = 12;
    localparam int MAX_LAT = 6;
    localparam int K_LOAD = 0, K_ADV = 1, K_WAIT = 2, K_DONE = 3;

    typedef struct {
        bit busy; bit done; bit mi; bit sl; int idx; int saddr; logic [3:0] mask;
        bit nl; bit push; int taddr; bit src; bit cap; int caddr; int pass;
    } exp_t;

    typedef struct { int kind; exp_t o; } act_t;

    typedef struct {
        int s; int t; int mode;
        int loads; int pushes; int caps; int nls; int locks; int done_c;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pass_scheduler_if #(.PE_NUM(PE_NUM), .LEN_W(LEN_W)) bus ();

    pass_scheduler #(.PE_NUM(PE_NUM), .LEN_W(LEN_W), .MAX_LAT(MAX_LAT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    function automatic logic [62:0] raw_act();
        return {bus.o_busy, bus.o_done, bus.o_max_init, bus.o_s_load, bus.o_s_idx,
                bus.o_s_addr, bus.o_pe_mask, bus.o_newline, bus.o_t_push, bus.o_t_addr,
                bus.o_t_src, bus.o_cap_en, bus.o_cap_addr, bus.o_pass, bus.o_lock};
    endfunction

    function automatic logic [61:0] pack_act();
        return {bus.o_busy, bus.o_done, bus.o_max_init, bus.o_s_load,
                bus.o_s_load ? bus.o_s_idx : 2'd0, bus.o_s_load ? bus.o_s_addr : 12'd0,
                bus.o_pe_mask, bus.o_newline, bus.o_t_push,
                bus.o_t_push ? bus.o_t_addr : 12'd0, bus.o_t_push & bus.o_t_src,
                bus.o_cap_en, bus.o_cap_en ? bus.o_cap_addr : 12'd0, bus.o_pass};
    endfunction

    function automatic logic [61:0] pack_exp(input exp_t e);
        return {e.busy, e.done, e.mi, e.sl, e.sl ? 2'(e.idx) : 2'd0,
                e.sl ? 12'(e.saddr) : 12'd0, e.mask, e.nl, e.push,
                e.push ? 12'(e.taddr) : 12'd0, e.push ? e.src : 1'b0,
                e.cap, e.cap ? 12'(e.caddr) : 12'd0, 12'(e.pass)};
    endfunction

    // mode: 0 no stall, 1 random stall, 2 three stalls at adv 2, 3 stray start while streaming
    task automatic run_job(input int s, input int t, input int mode,
                           output int n_load, output int n_push, output int n_cap,
                           output int n_nl, output int n_lock, output int done_c);
        act_t q[$];
        act_t a;
        exp_t e;
        int   np, n, lastp, stall_left;
        bit   stall, pulsed, got_done, lock_exp;

        lastp = 0;
        if (s != 0 && t != 0) begin
            np    = (s + PE_NUM - 1) / PE_NUM;
            lastp = np - 1;
            for (int p = 0; p < np; p++) begin
                n = (p == np - 1) ? s - (np - 1) * PE_NUM : PE_NUM;
                for (int j = 0; j < n; j++) begin
                    a.kind = K_LOAD; a.o = '{default: 0};
                    a.o.busy = 1; a.o.sl = 1; a.o.idx = j; a.o.saddr = p * PE_NUM + j;
                    a.o.mask = 4'((1 << n) - 1); a.o.pass = p;
                    q.push_back(a);
                end
                for (int k = 0; k < t + n; k++) begin
                    a.kind = K_ADV; a.o = '{default: 0};
                    a.o.busy = 1; a.o.mask = 4'((1 << n) - 1); a.o.pass = p;
                    a.o.push = (k < t); a.o.taddr = k; a.o.src = (p != 0);
                    a.o.nl = (k == 0); a.o.cap = (k >= n) && (p != np - 1); a.o.caddr = k - n;
                    q.push_back(a);
                end
            end
        end
        for (int w = 0; w < MAX_LAT; w++) begin
            a.kind = K_WAIT; a.o = '{default: 0}; a.o.busy = 1; a.o.pass = lastp;
            q.push_back(a);
        end
        a.kind = K_DONE; a.o = '{default: 0}; a.o.done = 1; a.o.pass = lastp;
        q.push_back(a);

        n_load = 0; n_push = 0; n_cap = 0; n_nl = 0; n_lock = 0; done_c = -1;
        stall_left = 3; pulsed = 0; got_done = 0;

        @(negedge clk);
        bus.i_s_len = 12'(s);
        bus.i_t_len = 12'(t);
        bus.i_start = 1'b1;
        e = '{default: 0}; e.busy = 1; e.mi = 1;

        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            bus.i_start = 1'b0;
            check($sformatf("trace s=%0d t=%0d cyc=%0d", s, t, c), 64'(pack_act()), 64'(pack_exp(e)));
            if (bus.o_s_load)  n_load++;
            if (bus.o_t_push)  n_push++;
            if (bus.o_cap_en)  n_cap++;
            if (bus.o_newline) n_nl++;
            if (bus.o_done && done_c < 0) done_c = c;
            if (e.done) begin
                got_done = 1;
                break;
            end
            stall = 0;
            if (mode == 1) stall = ($urandom_range(0, 3) == 0);
            if (q.size() > 0 && q[0].kind == K_ADV) begin
                if (mode == 2 && q[0].o.pass == 0 && q[0].o.taddr == 2 && stall_left > 0) begin
                    stall = 1;
                    stall_left--;
                end
                if (mode == 3 && q[0].o.pass == 0 && q[0].o.taddr == 1 && !pulsed) begin
                    bus.i_start = 1'b1; bus.i_s_len = 12'd1; bus.i_t_len = 12'd1;
                    pulsed = 1;
                end
            end
            bus.i_stall = stall;
            #1;
            lock_exp = stall && (q.size() > 0) && (q[0].kind == K_ADV);
            if (bus.o_lock) n_lock++;
            check($sformatf("lock s=%0d t=%0d cyc=%0d", s, t, c), 64'(bus.o_lock), 64'(lock_exp));
            if (q.size() == 0) begin
                e = '{default: 0};
            end else if (lock_exp) begin
                e = '{default: 0}; e.busy = 1; e.mask = q[0].o.mask; e.pass = q[0].o.pass;
            end else begin
                a = q.pop_front();
                e = a.o;
            end
        end
        bus.i_stall = 1'b0;
        bus.i_start = 1'b0;
        if (!got_done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout s=%0d t=%0d: got no finish within budget required done", s, t);
        end
        for (int k = 0; k < 200 && bus.o_busy; k++) @(negedge clk);
    endtask

    vec_t tbl[9];
    int   ld, ps, cp, nl, lk, dc;

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: got simulation still running required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{s: 3, t: 5, mode: 0, loads: 3, pushes: 5,  caps: 0, nls: 1, locks: 0, done_c: 19};
        tbl[1] = '{s: 9, t: 4, mode: 0, loads: 9, pushes: 12, caps: 8, nls: 3, locks: 0, done_c: 38};
        tbl[2] = '{s: 4, t: 0, mode: 0, loads: 0, pushes: 0,  caps: 0, nls: 0, locks: 0, done_c: 8};
        tbl[3] = '{s: 0, t: 7, mode: 0, loads: 0, pushes: 0,  caps: 0, nls: 0, locks: 0, done_c: 8};
        tbl[4] = '{s: 8, t: 1, mode: 0, loads: 8, pushes: 2,  caps: 1, nls: 2, locks: 0, done_c: 26};
        tbl[5] = '{s: 1, t: 1, mode: 0, loads: 1, pushes: 1,  caps: 0, nls: 1, locks: 0, done_c: 11};
        tbl[6] = '{s: 5, t: 3, mode: 0, loads: 5, pushes: 6,  caps: 3, nls: 2, locks: 0, done_c: 24};
        tbl[7] = '{s: 3, t: 5, mode: 2, loads: 3, pushes: 5,  caps: 0, nls: 1, locks: 3, done_c: 22};
        tbl[8] = '{s: 9, t: 4, mode: 3, loads: 9, pushes: 12, caps: 8, nls: 3, locks: 0, done_c: 38};

        rst_n = 1'b0;
        bus.i_start = 1'b0;
        bus.i_s_len = '0;
        bus.i_t_len = '0;
        bus.i_stall = 1'b0;
        @(negedge clk);
        check("reset_outputs", 64'(raw_act()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_job(tbl[i].s, tbl[i].t, tbl[i].mode, ld, ps, cp, nl, lk, dc);
            check($sformatf("vec%0d loads", i),   64'(ld), 64'(tbl[i].loads));
            check($sformatf("vec%0d pushes", i),  64'(ps), 64'(tbl[i].pushes));
            check($sformatf("vec%0d caps", i),    64'(cp), 64'(tbl[i].caps));
            check($sformatf("vec%0d newline", i), 64'(nl), 64'(tbl[i].nls));
            check($sformatf("vec%0d lock", i),    64'(lk), 64'(tbl[i].locks));
            check($sformatf("vec%0d done_cyc", i), 64'(dc), 64'(tbl[i].done_c));
        end

        // Abort during LOAD_S, then a fresh job must run cleanly.
        @(negedge clk);
        bus.i_s_len = 12'd9; bus.i_t_len = 12'd4; bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", 64'(raw_act()), 64'd0);
        @(negedge clk);
        check("rst_hold_outputs", 64'(raw_act()), 64'd0);
        rst_n = 1'b1;
        run_job(9, 4, 0, ld, ps, cp, nl, lk, dc);
        check("after_rst loads", 64'(ld), 64'd9);
        check("after_rst done_cyc", 64'(dc), 64'd38);

        for (int r = 0; r < 25; r++) begin
            int s, t;
            s = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 13);
            t = $urandom_range(0, 9);
            run_job(s, t, 1, ld, ps, cp, nl, lk, dc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
